// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the fetch stage: widths, control-flow opcodes and FSM states.
// The PC and decode stages import these as well.
package fetch_ctrl_pkg;

  localparam int IW = 16;
  localparam int DW = 8;

  localparam logic [3:0] OP_BEQ = 4'hB;
  localparam logic [3:0] OP_JMP = 4'hC;
  localparam logic [3:0] OP_BNE = 4'hD;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

endpackage

// File: rtl/fetch_ctrl_dec.sv
// Combinational decode of the instruction register: classifies jump, taken branch and halt,
// and forms the absolute jump target within the page of the delay-slot address.
module fetch_dec
  import fetch_ctrl_pkg::*;
(
  input  logic [IW-1:0] ir_i,
  input  logic          ir_valid_i,
  input  logic          zero_i,
  input  logic [3:0]    pc_page_i,
  output logic          take_j_o,
  output logic          take_b_o,
  output logic          is_hlt_o,
  output logic [IW-1:0] jump_tgt_o
);

  logic [3:0] op;

  assign op = ir_i[15:12];

  assign take_j_o   = ir_valid_i & (op == OP_JMP);
  assign take_b_o   = ir_valid_i & (((op == OP_BEQ) & zero_i) | ((op == OP_BNE) & ~zero_i));
  assign is_hlt_o   = ir_valid_i & (op == OP_HLT);
  assign jump_tgt_o = {pc_page_i, ir_i[11:0]};

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch controller: instruction register, RUN/HALT FSM and PC control mux.
// Optional performance counters are enabled by defining FETCH_CTRL_PERF_CNT_EN.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [IW-1:0] pc_i,
  input  logic [IW-1:0] instr_i,
  input  logic          instr_valid_i,
  input  logic          zero_i,
  output logic          jump_o,
  output logic          branch_o,
  output logic [DW-1:0] displacement_o,
  output logic [IW-1:0] jump_tgt_o,
  output logic [IW-1:0] ir_o,
  output logic [IW-1:0] ir_pc_o,
  output logic          ir_valid_o,
  output logic          halted_o
`ifdef FETCH_CTRL_PERF_CNT_EN
  ,
  output logic [15:0]   stall_cnt_o,
  output logic [15:0]   flush_cnt_o
`endif
);

  state_e        state_q;
  logic [IW-1:0] ir_q;
  logic [IW-1:0] ir_pc_q;
  logic          ir_valid_q;

  logic          take_j;
  logic          take_b;
  logic          is_hlt;
  logic          redirect;
  logic [IW-1:0] dec_tgt;

  fetch_dec u_dec (
    .ir_i       (ir_q),
    .ir_valid_i (ir_valid_q),
    .zero_i     (zero_i),
    .pc_page_i  (pc_i[15:12]),
    .take_j_o   (take_j),
    .take_b_o   (take_b),
    .is_hlt_o   (is_hlt),
    .jump_tgt_o (dec_tgt)
  );

  assign redirect = take_j | take_b;

  // Halt outranks redirect, which outranks an imem stall; a zero displacement holds the PC.
  always_comb begin
    jump_o         = 1'b0;
    branch_o       = 1'b0;
    displacement_o = '0;
    jump_tgt_o     = dec_tgt;
    if (rst_i) begin
      jump_tgt_o = '0;
    end else if ((state_q == ST_HALT) || is_hlt) begin
      branch_o = 1'b1;
    end else if (take_j) begin
      jump_o = 1'b1;
    end else if (take_b) begin
      branch_o       = 1'b1;
      displacement_o = ir_q[DW-1:0];
    end else if (!instr_valid_i) begin
      branch_o = 1'b1;
    end
  end

  // The delay-slot fetch is dropped whenever the IR redirects or halts.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_RUN;
      ir_q       <= '0;
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (redirect || is_hlt) begin
            ir_valid_q <= 1'b0;
            if (is_hlt) begin
              state_q <= ST_HALT;
            end
          end else if (instr_valid_i) begin
            ir_q       <= instr_i;
            ir_pc_q    <= pc_i;
            ir_valid_q <= 1'b1;
          end else begin
            ir_valid_q <= 1'b0;
          end
        end
        ST_HALT: begin
          ir_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign ir_o       = ir_q;
  assign ir_pc_o    = ir_pc_q;
  assign ir_valid_o = ir_valid_q;
  assign halted_o   = (state_q == ST_HALT);

`ifdef FETCH_CTRL_PERF_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;
  logic        stall_ev;

  assign stall_ev = (state_q == ST_RUN) & ~instr_valid_i & ~redirect & ~is_hlt;

  // Both counters saturate rather than wrap.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_ev && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
    if (redirect && (flush_cnt_q != 16'hFFFF)) begin
      flush_cnt_d = flush_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sits between instruction memory and the program counter, on the opposite side of the PC's control interface.
- Consumes the instruction word returned for the current PC and latches it into an instruction register (IR) that feeds decode.
- Drives the PC's control inputs: jump, branch, displacement and jump target.
- Resolves jumps and conditional branches one cycle after fetch, squashes the delay-slot fetch, stalls the PC on memory wait, and halts on HLT.

Parameters:
- IW, 16: instruction and address width.
- DW, 8: branch displacement width, sign-extended by the PC.
- OP_BEQ, 4'hB: opcode, branch if zero_i = 1.
- OP_JMP, 4'hC: opcode, absolute jump.
- OP_BNE, 4'hD: opcode, branch if zero_i = 0.
- OP_HLT, 4'hF: opcode, halt fetch.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- pc_i  in  IW  current PC value, i.e. the address being fetched this cycle.
- instr_i  in  IW  imem read data for pc_i.
- instr_valid_i  in  1  instr_i is valid this cycle; 0 means imem wait.
- zero_i  in  1  ALU zero flag, valid in the cycle a branch sits in IR.
- jump_o  out  1  PC loads jump_tgt_o.
- branch_o  out  1  PC adds sign-extended displacement_o instead of 1.
- displacement_o  out  DW  branch offset.
- jump_tgt_o  out  IW  absolute jump target.
- ir_o  out  IW  instruction register to decode.
- ir_pc_o  out  IW  address of the instruction held in ir_o.
- ir_valid_o  out  1  ir_o holds a live instruction.
- halted_o  out  1  FSM is in HALT.

Behaviour:
- Reset (async, while rst_i = 1): ir_o = 0, ir_pc_o = 0, ir_valid_o = 0, state = RUN, halted_o = 0. All combinational control outputs are forced to 0 while rst_i is high.
- Decode: op = ir_o[15:12].
  - take_j = ir_valid_o & (op == OP_JMP).
  - take_b = ir_valid_o & ((op == OP_BEQ & zero_i) | (op == OP_BNE & ~zero_i)).
  - redirect = take_j | take_b.
  - is_hlt = ir_valid_o & (op == OP_HLT).
- Control outputs are combinational from IR, state and inputs; priority is highest first:
  1. state HALT or is_hlt: branch_o = 1, displacement_o = 0, so the PC holds.
  2. take_j: jump_o = 1, jump_tgt_o = {pc_i[15:12], ir_o[11:0]}, branch_o = 0.
  3. take_b: branch_o = 1, displacement_o = ir_o[7:0].
  4. ~instr_valid_i: branch_o = 1, displacement_o = 0 (stall, PC holds).
  5. Otherwise: jump_o = 0, branch_o = 0 (PC increments by 1).
  - jump_tgt_o = {pc_i[15:12], ir_o[11:0]} at all times; it is a don't-care unless jump_o = 1.
  - displacement_o = 0 whenever branch_o = 0.
- Branch semantics: PC already equals branch address + 1 in the resolve cycle, so the target is branch_addr + 1 + sext(disp). Wrap-around is modulo 2^16.
- Jump page: the upper 4 bits of the jump target come from pc_i (the delay-slot address), including at a 4K page boundary.
- IR update at the clock edge, state RUN:
  - redirect or is_hlt: ir_valid_o <= 0. The delay-slot instr_i is squashed even if instr_valid_i = 1. This is exactly one bubble.
  - Else if instr_valid_i: ir_o <= instr_i, ir_pc_o <= pc_i, ir_valid_o <= 1.
  - Else: ir_valid_o <= 0; ir_o and ir_pc_o hold their values.
- A redirect during an imem wait still redirects, since redirect outranks stall.
- FSM:
  - RUN -> HALT when is_hlt.
  - HALT is absorbing, with ir_valid_o = 0 and halted_o = 1.
  - Only rst_i leaves HALT.
- Reset mid-branch: the pending redirect is lost, the IR is cleared, and fetch restarts at the PC reset address.
- Back-to-back branches: impossible, because the squash guarantees ir_valid_o = 0 in the cycle after a redirect.

Optional Feature:
- Macro: FETCH_CTRL_PERF_CNT_EN.
- Defined: adds outputs stall_cnt_o[15:0] and flush_cnt_o[15:0].
  - Both reset to 0 and saturate at 16'hFFFF.
  - stall_cnt_o increments on each RUN cycle with ~instr_valid_i & ~redirect & ~is_hlt.
  - flush_cnt_o increments on each redirect cycle.
- Undefined: neither the ports nor the counters exist, and all other behaviour is identical.

Decomposition:
- Shared package: opcode constants (OP_BEQ/OP_JMP/OP_BNE/OP_HLT), IW/DW, and the RUN/HALT state encoding. The PC and decode stage reuse these.
- Sub-module fetch_dec (combinational): takes ir_o, ir_valid_o and zero_i; produces take_j, take_b, is_hlt and jump_tgt_o.
- The top level holds the IR, the FSM, the priority mux and the optional counters.

Test Plan:
- Sequential fetch: after reset, imem at 0..3 = 16'h1000..16'h1003, valid always 1. Required: jump_o = 0 and branch_o = 0 every cycle; ir_o = 16'h1000, 16'h1001, ... with ir_pc_o = 0, 1, ...
- BEQ taken: instr 16'hB0FE at addr 5, zero_i = 1. Required: in the resolve cycle branch_o = 1 and displacement_o = 8'hFE; the next PC is 4; ir_valid_o = 0 for exactly one cycle.
- BNE not taken: instr 16'hD005, zero_i = 1. Required: branch_o = 0, no squash, PC increments.
- JMP: instr 16'hC234 at addr 16'h1FFF (pc_i = 16'h2000 in the resolve cycle). Required: jump_o = 1, jump_tgt_o = 16'h2234, one bubble.
- Imem wait: instr_valid_i = 0 for 3 cycles. Required: branch_o = 1 and displacement_o = 0 for 3 cycles, ir_valid_o = 0, PC unchanged. With FETCH_CTRL_PERF_CNT_EN defined: stall_cnt_o = 3.
- HLT then reset: instr 16'hF000. Required: halted_o = 1 and the PC holds indefinitely. Asserting rst_i mid-HALT returns state RUN and ir_valid_o = 0 immediately, without waiting for a clock edge.
